mips_multicycle_control: RTL

Main control unit for the multicycle MIPS datapath. It sequences a shared datapath one instruction at a time: instruction fetch, decode, ALU use, memory access and register write-back. In DECODE it also sets up the branch-target computation: PC+4 plus the sign-extended immediate passed through the 32-bit left-shift-by-2 unit. Instructions supported: R-type (add, sub, and, or, slt), lw, sw, beq, addi and j.

---
 rtl/mips_ctrl_pkg.sv | 42 ++++
 rtl/mips_alu_decoder.sv | 36 +++
 rtl/mips_multicycle_control.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared state, opcode, funct and ALU encodings for the multicycle MIPS control
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_alu_decoder.sv
// rtl/mips_alu_decoder.sv - maps alu_op and funct to the ALU control code
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_ok
);

    logic [2:0] funct_ctrl;

    // funct_ok ignores alu_op so DECODE can vet an R-type before RTYPEEX.
    always_comb begin
        funct_ctrl = ALU_ADD;
        funct_ok   = 1'b1;
        case (funct)
            FN_ADD:  funct_ctrl = ALU_ADD;
            FN_SUB:  funct_ctrl = ALU_SUB;
            FN_AND:  funct_ctrl = ALU_AND;
            FN_OR:   funct_ctrl = ALU_OR;
            FN_SLT:  funct_ctrl = ALU_SLT;
            default: funct_ok   = 1'b0;
        endcase
    end

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_FUNCT: alu_control = funct_ctrl;
            default:     alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - Moore FSM sequencing the shared multicycle MIPS datapath
module mips_multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_control,
    output logic       illegal_op
);

    state_t     state_q, state_d;
    state_t     out_state;
    logic [1:0] alu_op;
    logic       pc_write, branch;
    logic       ir_write_s, mem_write_s, reg_write_s;
    logic       funct_ok;
    logic       decode_bad;

    mips_alu_decoder u_alu_dec (
        .alu_op      (alu_op),
        .funct       (funct),
        .alu_control (alu_control),
        .funct_ok    (funct_ok)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        decode_bad = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: decode_bad = 1'b0;
            OP_RTYPE: decode_bad = !funct_ok;
            default:  decode_bad = 1'b1;
        endcase
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = funct_ok ? RTYPEEX : FETCH;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_d = MEMWB;
            RTYPEEX: state_d = RTYPEWB;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    // Under reset the selects show FETCH values; enables are masked below.
    assign out_state = rst ? FETCH : state_q;

    always_comb begin
        iord        = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write_s = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_src      = 2'b00;
        alu_op      = ALUOP_ADD;
        pc_write    = 1'b0;
        branch      = 1'b0;
        case (out_state)
            FETCH: begin
                alu_src_b  = 2'b01;
                ir_write_s = 1'b1;
                pc_write   = 1'b1;
            end
            DECODE:  alu_src_b = 2'b11;
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD:   iord = 1'b1;
            MEMWB: begin
                mem_to_reg  = 1'b1;
                reg_write_s = 1'b1;
            end
            MEMWR: begin
                iord        = 1'b1;
                mem_write_s = 1'b1;
            end
            RTYPEEX: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                reg_dst     = 1'b1;
                reg_write_s = 1'b1;
            end
            BEQEX: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            ADDIWB:  reg_write_s = 1'b1;
            JEX: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign ir_write   = ir_write_s  & ~rst;
    assign mem_write  = mem_write_s & ~rst;
    assign reg_write  = reg_write_s & ~rst;
    assign pc_en      = (pc_write | (branch & zero)) & ~rst;
    assign illegal_op = (state_q == DECODE) & decode_bad & ~rst;

endmodule
